// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared state encoding and default geometry for the instruction cache
package inst_cache_pkg;
  localparam int DEF_INDEX_BITS  = 6;
  localparam int DEF_OFFSET_BITS = 2;
  typedef enum logic {ICACHE_IDLE = 1'b0, ICACHE_FILL = 1'b1} icache_state_e;
endpackage

// File: rtl/inst_cache_store.sv
// inst_cache_store: tag/valid/data arrays of the direct-mapped instruction cache
//   clk, rst          clock, async active-low reset (clears valid bits only)
//   i_rd_index/offset combinational read port -> o_rd_valid, o_rd_tag, o_rd_data
//   i_we, i_wr_*      word write into data[i_wr_index][i_wr_offset]
//   i_commit          marks line i_wr_index valid and stores i_wr_tag
module inst_cache_store #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  i_rd_index,
  input  logic [OFFSET_BITS-1:0] i_rd_offset,
  output logic                   o_rd_valid,
  output logic [TAG_BITS-1:0]    o_rd_tag,
  output logic [31:0]            o_rd_data,
  input  logic                   i_we,
  input  logic [INDEX_BITS-1:0]  i_wr_index,
  input  logic [OFFSET_BITS-1:0] i_wr_offset,
  input  logic [31:0]            i_wr_data,
  input  logic                   i_commit,
  input  logic [TAG_BITS-1:0]    i_wr_tag
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;
  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES*WORDS];
  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[{i_rd_index, i_rd_offset}];
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_valid <= '0;
    else if (i_commit) r_valid[i_wr_index] <= 1'b1;
  // data and tags need no reset: a line is only read once its valid bit is set
  always_ff @(posedge clk) begin
    if (i_we) r_data[{i_wr_index, i_wr_offset}] <= i_wr_data;
    if (i_commit) r_tag[i_wr_index] <= i_wr_tag;
  end
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache with line fill from the memory controller
//   clk, rst (async active-low), rdy (0 freezes all state)
//   fetch_enable/cache_pc -> cache_valid (1-cycle pulse) / cache_inst
//   should_reset          kills a pending response; an in-flight fill still completes
//   mc_req/mc_addr        one word read per transaction, completed by mc_done/mc_data
//   ICACHE_PERF_EN        when defined adds hit_count/miss_count outputs
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_enable,
  input  logic [31:0] cache_pc,
  output logic        cache_valid,
  output logic [31:0] cache_inst,
  input  logic        should_reset,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int LO       = OFFSET_BITS + 2;
  localparam int TAG_BITS = 32 - LO - INDEX_BITS;
  icache_state_e          r_state, w_state_nxt;
  logic [OFFSET_BITS-1:0] r_cnt;
  logic                   r_cache_valid;
  logic [31:0]            r_cache_inst;
  logic                   r_mc_req;
  logic [31:0]            r_mc_addr;
  logic                   w_lookup, w_hit, w_miss, w_done, w_last;
  logic                   w_rd_valid;
  logic [TAG_BITS-1:0]    w_rd_tag;
  logic [31:0]            w_rd_data;
  logic [1:0]             w_unused_pc;
  assign w_unused_pc = cache_pc[1:0];
  assign cache_valid = r_cache_valid;
  assign cache_inst  = r_cache_inst;
  assign mc_req      = r_mc_req;
  assign mc_addr     = r_mc_addr;
  inst_cache_store #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (cache_pc[LO+INDEX_BITS-1:LO]),
    .i_rd_offset(cache_pc[LO-1:2]),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (rdy && w_done),
    .i_wr_index (r_mc_addr[LO+INDEX_BITS-1:LO]),
    .i_wr_offset(r_cnt),
    .i_wr_data  (mc_data),
    .i_commit   (rdy && w_done && w_last),
    .i_wr_tag   (r_mc_addr[31:LO+INDEX_BITS])
  );
  // no lookup while a response is showing: the fetcher drops its request on that edge
  always_comb begin
    w_lookup    = r_state == ICACHE_IDLE && fetch_enable && !r_cache_valid && !should_reset;
    w_hit       = w_lookup && w_rd_valid && w_rd_tag == cache_pc[31:LO+INDEX_BITS];
    w_miss      = w_lookup && !w_hit;
    w_done      = r_state == ICACHE_FILL && r_mc_req && mc_done;
    w_last      = &r_cnt;
    w_state_nxt = w_miss ? ICACHE_FILL : (w_done && w_last) ? ICACHE_IDLE : r_state;
  end
  // fill address tracks the word being fetched, so it also carries the fill tag/index
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state       <= ICACHE_IDLE;
      r_cnt         <= '0;
      r_cache_valid <= 1'b0;
      r_cache_inst  <= '0;
      r_mc_req      <= 1'b0;
      r_mc_addr     <= '0;
    end else if (rdy) begin
      r_state       <= w_state_nxt;
      r_cache_valid <= w_hit;
      if (w_hit) r_cache_inst <= w_rd_data;
      if (w_miss) begin
        r_mc_req  <= 1'b1;
        r_mc_addr <= {cache_pc[31:LO], {LO{1'b0}}};
      end else if (w_done) begin
        r_mc_req <= 1'b0;
        r_cnt    <= r_cnt + 1'b1;
        if (!w_last) r_mc_addr <= r_mc_addr + 32'd4;
      end else if (r_state == ICACHE_FILL) r_mc_req <= 1'b1;
    end
`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_count, r_miss_count;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (rdy) begin
      if (w_hit) r_hit_count <= r_hit_count + 32'd1;
      if (w_miss) r_miss_count <= r_miss_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: scoreboard bench for inst_cache against a line-level cache model and a memory responder
module tb_inst_cache;
  logic        clk = 0, rst = 0, rdy = 1, fetch_enable = 0, should_reset = 0;
  logic [31:0] cache_pc = 0, cache_inst, mc_addr, mc_data = 0;
  logic        cache_valid, mc_req, mc_done = 0;
  int          n_checks = 0, n_fail = 0, trans = 0, t0 = 0, lat = 0;
  bit          hold_mem = 0, prev_v = 0;
  logic [31:0] exp_q[$], addr_q[$];
  bit          m_valid[64];
  logic [21:0] m_tag[64];

  inst_cache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .fetch_enable(fetch_enable), .cache_pc(cache_pc),
    .cache_valid(cache_valid), .cache_inst(cache_inst), .should_reset(should_reset),
    .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // memory controller: random latency, one word per request, holds mc_done while rdy=0
  initial forever begin
    @(posedge clk); #1;
    if (!rst) begin
      mc_done = 0;
      lat = 0;
    end else if (mc_done) begin
      if (rdy) begin
        mc_done = 0;
        trans++;
        check("mc_req_drop", mc_req, 0);
      end
    end else if (mc_req && !hold_mem) begin
      if (lat == 0) begin
        if (addr_q.size() == 0) check("mc_req_spurious", mc_req, 0);
        else check("mc_addr", mc_addr, addr_q.pop_front());
        mc_data = mem(mc_addr);
        mc_done = 1;
        lat = $urandom_range(0, 3);
      end else lat--;
    end
  end

  // response monitor
  initial forever begin
    @(negedge clk);
    if (rst && cache_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", cache_valid, 0);
      else check("cache_inst", cache_inst, exp_q.pop_front());
      check("valid_one_cycle", prev_v, 0);
    end
    prev_v = cache_valid;
  end

  task automatic issue(input logic [31:0] pc, input bit expect_resp, output bit miss);
    int idx;
    idx  = int'(pc[9:4]);
    miss = !(m_valid[idx] && m_tag[idx] == pc[31:10]);
    if (miss) begin
      for (int w = 0; w < 4; w++) addr_q.push_back({pc[31:4], 4'h0} + 32'(4 * w));
      m_valid[idx] = 1;
      m_tag[idx]   = pc[31:10];
    end
    if (expect_resp) exp_q.push_back(mem({pc[31:2], 2'b00}));
    t0 = trans;
    fetch_enable = 1;
    cache_pc = pc;
  endtask

  task automatic wait_resp(input bit miss, input bit chk_lat);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      got = cache_valid;
    end
    fetch_enable = 0;
    check("resp_seen", got, 1);
    if (!got && exp_q.size() > 0) void'(exp_q.pop_front());
    check("mc_txns", trans - t0, miss ? 4 : 0);
    if (chk_lat && !miss) check("hit_latency", cyc, 1);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] pc, input bit exp_miss);
    bit miss;
    issue(pc, 1, miss);
    check("model_miss", miss, exp_miss);
    wait_resp(miss, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit miss, seen;
    int cyc;
    repeat (2) @(negedge clk);
    check("rst_valid", cache_valid, 0);
    check("rst_inst", cache_inst, 0);
    check("rst_req", mc_req, 0);
    check("rst_addr", mc_addr, 0);
    rst = 1;
    @(negedge clk);
    fetch(32'h0000_0000, 1);
    fetch(32'h0000_0008, 0);
    fetch(32'h0000_0400, 1);
    fetch(32'h0000_0000, 1);
    fetch(32'h0000_0404, 1);
    // flush while the fill is in flight: fill completes silently, line becomes usable
    issue(32'h0000_0000, 0, miss);
    cyc = 0;
    while (!(mc_done && trans == t0 + 1) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("flush_second_done", trans - t0, 1);
    should_reset = 1;
    fetch_enable = 0;
    @(negedge clk);
    should_reset = 0;
    seen = 0;
    cyc = 0;
    while (trans != t0 + 4 && cyc < 200) begin
      seen |= cache_valid;
      @(negedge clk);
      cyc++;
    end
    repeat (3) begin
      seen |= cache_valid;
      @(negedge clk);
    end
    check("flush_no_valid", seen, 0);
    check("flush_fill_txns", trans - t0, 4);
    fetch(32'h0000_0000, 0);
    // flush in the same cycle as a hitting lookup
    t0 = trans;
    fetch_enable = 1;
    should_reset = 1;
    cache_pc = 32'h0000_0004;
    @(negedge clk);
    check("flush_hit_valid", cache_valid, 0);
    should_reset = 0;
    fetch_enable = 0;
    @(negedge clk);
    check("flush_hit_valid2", cache_valid, 0);
    check("flush_hit_txns", trans - t0, 0);
    // rdy low for three cycles during a fill
    hold_mem = 1;
    issue(32'h0000_2000, 1, miss);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mc_req && cyc < 10);
    rdy = 0;
    repeat (3) begin
      @(negedge clk);
      check("rdy_req_held", mc_req, 1);
      check("rdy_addr_held", mc_addr, 32'h0000_2000);
      check("rdy_no_valid", cache_valid, 0);
    end
    rdy = 1;
    hold_mem = 0;
    wait_resp(miss, 0);
    // async reset during a fill
    hold_mem = 1;
    issue(32'h0000_1230, 0, miss);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mc_req && cyc < 10);
    check("rst_fill_started", mc_req, 1);
    rst = 0;
    #1;
    check("async_rst_req", mc_req, 0);
    check("async_rst_addr", mc_addr, 0);
    @(negedge clk);
    rst = 1;
    fetch_enable = 0;
    hold_mem = 0;
    addr_q.delete();
    exp_q.delete();
    foreach (m_valid[i]) m_valid[i] = 0;
    @(negedge clk);
    fetch(32'h0000_0000, 1);
    // random fetches over a few conflicting lines
    repeat (40) begin
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      issue(pc, 1, miss);
      wait_resp(miss, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
